// File: rtl/banked_reg_file.sv
// Architectural register file: 16 registers with a per-mode banked SP, auto-incrementing PC and atomic IRQ save/restore.
// Optional write-to-read forwarding is built only when BANKED_REG_FILE_BYPASS_EN is defined.
package reg_pkg;
    typedef enum logic [3:0] {
        REG_R0, REG_R1, REG_R2, REG_R3, REG_R4, REG_R5, REG_R6, REG_R7,
        REG_R8, REG_R9, REG_R10, REG_R11, REG_R12, REG_FP, REG_SP, REG_PC
    } reg_e;

    typedef enum logic {
        MODE_USER       = 1'b0,
        MODE_SUPERVISOR = 1'b1
    } cpu_mode_e;

    typedef struct packed {
        logic [3:0] alu_status;
        logic       imask;
        cpu_mode_e  mode;
    } status_t;
endpackage

module banked_reg_file
    import reg_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned PC_STEP  = 1,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned IRQ_VEC  = 16'h0010
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD-1:0][3:0]         rd_sel,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    input  logic                           wr_en,
    input  logic [3:0]                     wr_sel,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           pc_inc,
    input  logic                           status_wr_en,
    input  status_t                        status_in,
    input  logic                           irq_entry,
    input  logic                           irq_return,
    output status_t                        status,
    output logic [DATA_W-1:0]              pc
);
    localparam int unsigned NUM_GPR = 14;  // R0-R12 and FP
    localparam logic [DATA_W-1:0] PC_STEP_W  = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] RESET_PC_W = DATA_W'(RESET_PC);
    localparam logic [DATA_W-1:0] IRQ_VEC_W  = DATA_W'(IRQ_VEC);
    localparam status_t STATUS_RESET = '{alu_status: 4'h0, imask: 1'b1, mode: MODE_SUPERVISOR};

    if (DATA_W < 8) begin : g_bad_data_w
        $error("banked_reg_file: DATA_W must be >= 8");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("banked_reg_file: NUM_RD must be 1..4");
    end

    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] gpr_d [NUM_GPR];
    logic [DATA_W-1:0] usp_q, usp_d, ssp_q, ssp_d;
    logic [DATA_W-1:0] pc_q, pc_d, saved_pc_q, saved_pc_d;
    status_t           status_q, status_d, saved_status_q, saved_status_d;

    logic              is_super;
    logic [DATA_W-1:0] sp_cur;

    assign is_super = (status_q.mode == MODE_SUPERVISOR);
    assign sp_cur   = is_super ? ssp_q : usp_q;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        gpr_d          = gpr_q;
        usp_d          = usp_q;
        ssp_d          = ssp_q;
        pc_d           = pc_q;
        saved_pc_d     = saved_pc_q;
        status_d       = status_q;
        saved_status_d = saved_status_q;

        if (wr_en && wr_sel <= REG_FP) begin
            gpr_d[wr_sel] = wr_data;
        end
        if (wr_en && wr_sel == REG_SP) begin
            if (is_super) ssp_d = wr_data;
            else          usp_d = wr_data;
        end

        if (irq_entry) begin
            saved_pc_d     = pc_q;
            saved_status_d = status_q;
            pc_d           = IRQ_VEC_W;
            status_d.mode  = MODE_SUPERVISOR;
            status_d.imask = 1'b1;
        end else if (irq_return) begin
            pc_d     = saved_pc_q;
            status_d = saved_status_q;
        end else begin
            if (wr_en && wr_sel == REG_PC) pc_d = wr_data;
            else if (pc_inc)               pc_d = pc_q + PC_STEP_W;
            if (status_wr_en) begin
                // User code may only touch the ALU flags; imask and mode are privileged.
                if (is_super) status_d = status_in;
                else          status_d.alu_status = status_in.alu_status;
            end
        end
    end

    // NOTE: the register array is reset explicitly because software relies on zeroed registers after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
            usp_q          <= '0;
            ssp_q          <= '0;
            pc_q           <= RESET_PC_W;
            saved_pc_q     <= '0;
            status_q       <= STATUS_RESET;
            saved_status_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge _d value.
            gpr_q          <= gpr_d;
            usp_q          <= usp_d;
            ssp_q          <= ssp_d;
            pc_q           <= pc_d;
            saved_pc_q     <= saved_pc_d;
            status_q       <= status_d;
            saved_status_q <= saved_status_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_sel[p] == REG_PC)      rd_data[p] = pc_q;
            else if (rd_sel[p] == REG_SP) rd_data[p] = sp_cur;
            else                          rd_data[p] = gpr_q[rd_sel[p]];
`ifdef BANKED_REG_FILE_BYPASS_EN
            // SP reads and writes both follow the current mode, so a matching SP select is always the same bank.
            if (wr_en && rd_sel[p] == wr_sel &&
                !(wr_sel == REG_PC && (irq_entry || irq_return))) begin
                rd_data[p] = wr_data;
            end
`endif
        end
    end

    assign status = status_q;
    assign pc     = pc_q;

endmodule
